// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bundle: redirect/call/ret requests in, fetch address and RAS status out.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus;
    logic             ras_empty;
    logic             ras_full;
    logic             misalign;
    logic             ret_err;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret,
        input  pc_out, pc_plus, ras_empty, ras_full, misalign, ret_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret,
        output pc_out, pc_plus, ras_empty, ras_full, misalign, ret_err
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential advance, stall hold and redirect.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      INC       = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    localparam logic [WIDTH-1:0] LowMask = WIDTH'(INC - 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic             misalign_q, misalign_d;
    logic             ret_err_q, ret_err_d;
    logic             pop;
    logic [WIDTH-1:0] ras_top;

    assign pc_plus = pc_q + WIDTH'(INC);

`ifdef PC_RAS_EN
    localparam int unsigned  PtrW   = $clog2(RAS_DEPTH);
    localparam logic [PtrW:0]   CntMax = (PtrW + 1)'(RAS_DEPTH);
    localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PtrW-1:0]  sp_q, sp_d, top_idx;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             push, empty;

    // sp_q points at the next free slot; wrapping it overwrites the oldest entry when full.
    assign top_idx = sp_q - PtrOne;
    assign ras_top = ras_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign push    = bus.redirect_valid & bus.call;
    assign pop     = bus.ret & ~bus.redirect_valid & ~bus.stall & ~empty;

    always_comb begin
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        ret_err_d = bus.ret & ~bus.redirect_valid & ~bus.stall & empty;
        if (push) begin
            sp_d = sp_q + PtrOne;
            if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
        end else if (pop) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ras_q[sp_q] <= pc_plus;
    end

    assign bus.ras_empty = empty;
    assign bus.ras_full  = (cnt_q == CntMax);
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras;

    assign unused_ras    = bus.call ^ bus.ret;
    assign pop           = 1'b0;
    assign ras_top       = '0;
    assign ret_err_d     = 1'b0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_target & ~LowMask;
            misalign_d = |(bus.redirect_target & LowMask);
        end else if (pop) begin
            pc_d = ras_top;
        end else if (!bus.stall) begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            ret_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ret_err_q  <= ret_err_d;
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.pc_plus  = pc_plus;
    assign bus.misalign = misalign_q;
    assign bus.ret_err  = ret_err_q;
endmodule
